// File: rtl/accumulator_alu.sv
// 4-bit accumulator, carry/link flag and ALU for the 4004 datapath.
// Results and the XCH write-back are registered; acc_zero is combinational.
module accumulator_alu (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] B,
    input  logic [3:0] alu_op,
    input  logic       alu_enable,
    input  logic       acc_load,
    input  logic [3:0] data_bus,
    output logic [3:0] acc,
    output logic       carry,
    output logic       acc_zero,
    output logic [3:0] wb_data,
    output logic       wb_valid
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_XCH = 4'h4;
    localparam logic [3:0] OP_CLB = 4'h5;
    localparam logic [3:0] OP_CLC = 4'h6;
    localparam logic [3:0] OP_IAC = 4'h7;
    localparam logic [3:0] OP_CMC = 4'h8;
    localparam logic [3:0] OP_CMA = 4'h9;
    localparam logic [3:0] OP_RAL = 4'hA;
    localparam logic [3:0] OP_RAR = 4'hB;
    localparam logic [3:0] OP_TCC = 4'hC;
    localparam logic [3:0] OP_DAC = 4'hD;
    localparam logic [3:0] OP_STC = 4'hE;
    localparam logic [3:0] OP_DAA = 4'hF;

    logic [3:0] acc_nxt;
    logic       carry_nxt;
    logic [4:0] sum;
    logic       xch_accept;

    always_comb begin
        acc_nxt   = acc;
        carry_nxt = carry;
        sum       = 5'd0;
        unique case (alu_op)
            OP_NOP: ;
            OP_ADD: begin
                sum       = {1'b0, acc} + {1'b0, B} + {4'd0, carry};
                acc_nxt   = sum[3:0];
                carry_nxt = sum[4];
            end
            // Carry acts as an inverted borrow: it is complemented on the way in.
            OP_SUB: begin
                sum       = {1'b0, acc} + {1'b0, ~B} + {4'd0, ~carry};
                acc_nxt   = sum[3:0];
                carry_nxt = sum[4];
            end
            OP_LD:  acc_nxt = B;
            OP_XCH: acc_nxt = B;
            OP_CLB: begin
                acc_nxt   = 4'd0;
                carry_nxt = 1'b0;
            end
            OP_CLC: carry_nxt = 1'b0;
            OP_IAC: begin
                sum       = {1'b0, acc} + 5'd1;
                acc_nxt   = sum[3:0];
                carry_nxt = sum[4];
            end
            OP_CMC: carry_nxt = ~carry;
            OP_CMA: acc_nxt = ~acc;
            OP_RAL: begin
                acc_nxt   = {acc[2:0], carry};
                carry_nxt = acc[3];
            end
            OP_RAR: begin
                acc_nxt   = {carry, acc[3:1]};
                carry_nxt = acc[0];
            end
            OP_TCC: begin
                acc_nxt   = {3'b000, carry};
                carry_nxt = 1'b0;
            end
            OP_DAC: begin
                sum       = {1'b0, acc} + 5'h0F;
                acc_nxt   = sum[3:0];
                carry_nxt = sum[4];
            end
            OP_STC: carry_nxt = 1'b1;
            // DAA only ever sets carry; it never clears an existing one.
            OP_DAA: begin
                if ((acc > 4'd9) || carry) begin
                    sum     = {1'b0, acc} + 5'd6;
                    acc_nxt = sum[3:0];
                    if (sum[4]) begin
                        carry_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign xch_accept = alu_enable && !acc_load && (alu_op == OP_XCH);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc      <= 4'd0;
            carry    <= 1'b0;
            wb_data  <= 4'd0;
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= xch_accept;
            if (xch_accept) begin
                wb_data <= acc;
            end
            // An immediate load wins over any op presented on the same edge.
            if (acc_load) begin
                acc <= data_bus;
            end else if (alu_enable) begin
                acc   <= acc_nxt;
                carry <= carry_nxt;
            end
        end
    end

    assign acc_zero = (acc == 4'd0);

endmodule
